ps2_rx_decoder: RTL and testbench

PS2_RX_DECODER -- requirements
Module: ps2_rx_decoder

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_rx_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_rx_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, constants and parameter defaults for the PS/2 receive decoder.
package ps2_pkg;
  localparam int unsigned FILT_LEN_DEF    = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 100000;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;

  localparam logic [7:0] PS2_EXT0 = 8'hE0;
  localparam logic [7:0] PS2_EXT1 = 8'hE1;
  localparam logic [7:0] PS2_BRK  = 8'hF0;

  // Keyboard status/ack bytes that carry no key information
  localparam int unsigned DISCARD_N = 6;
  localparam logic [DISCARD_N-1:0][7:0] DISCARD_CODES =
    {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_evt_t;

  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < DISCARD_N; i++) begin
      if (DISCARD_CODES[i] == b) hit = 1'b1;
    end
    return hit;
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter; the output only
// follows the input after FILT_LEN consecutive equal synchronized samples.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int unsigned RW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [RW-1:0] run;

  // Idle-high bus: everything parks at 1 while in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      filt  <= 1'b1;
      run   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        run <= '0;
      end else if (run == RW'(FILT_LEN - 1)) begin
        filt <= sync2;
        run  <= '0;
      end else begin
        run <= run + RW'(1);
      end
    end
  end
endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: line filtering, frame FSM with parity/stop/timeout
// checks, E0/E1/F0 prefix decode and a first-word-fall-through event FIFO.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN    = FILT_LEN_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic       CLK50M,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       iEVT_READY,
  output logic       oEVT_VALID,
  output logic [7:0] oEVT_CODE,
  output logic       oEVT_BREAK,
  output logic       oEVT_EXT,
  output logic       oERR,
  output logic       oOVF
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          clk_filt;
  logic          dat_filt;
  logic          clk_last;
  logic          sample_c;
  ps2_state_e    state;
  ps2_state_e    state_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_d;
  logic          parity;
  logic          parity_d;
  logic          byte_vld;
  logic          byte_vld_d;
  logic          err_d;
  logic          timeout_c;
  logic [TW-1:0] to_cnt;
  logic          ext;
  logic          ext_d;
  logic          brk;
  logic          brk_d;
  logic          push_c;
  ps2_evt_t      evt_c;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk(CLK50M), .reset(RESET), .raw(PS2_CLK), .filt(clk_filt)
  );
  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk(CLK50M), .reset(RESET), .raw(PS2_DAT), .filt(dat_filt)
  );

  assign sample_c = clk_last & ~clk_filt;

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      parity   <= 1'b0;
      byte_vld <= 1'b0;
      oERR     <= 1'b0;
      clk_last <= 1'b1;
      ext      <= 1'b0;
      brk      <= 1'b0;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_cnt  <= bit_cnt_d;
      parity   <= parity_d;
      byte_vld <= byte_vld_d;
      oERR     <= err_d;
      clk_last <= clk_filt;
      ext      <= ext_d;
      brk      <= brk_d;
    end
  end

  // Mid-frame inactivity counter; held at 0 while idle, saturating otherwise
  always_ff @(posedge CLK50M) begin
    if (RESET || sample_c || state == ST_IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  always_comb begin
    state_d    = state;
    shift_d    = shift;
    bit_cnt_d  = bit_cnt;
    parity_d   = parity;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    timeout_c  = (state != ST_IDLE) && !sample_c && (to_cnt >= TW'(TIMEOUT_CYC - 1));
    if (timeout_c) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (sample_c) begin
      case (state)
        ST_IDLE: begin
          if (!dat_filt) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_filt, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'(1);
          if (bit_cnt == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = dat_filt;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (dat_filt && (^{parity, shift})) byte_vld_d = 1'b1;
          else                                err_d      = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Prefix bytes only set flags; a key byte emits one event and clears them
  always_comb begin
    ext_d      = ext;
    brk_d      = brk;
    push_c     = 1'b0;
    evt_c.code = shift;
    evt_c.brk  = brk;
    evt_c.ext  = ext;
    if (timeout_c) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld) begin
      if (shift == PS2_EXT0 || shift == PS2_EXT1) begin
        ext_d = 1'b1;
      end else if (shift == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (!(is_discard(shift) && !ext && !brk)) begin
        push_c = 1'b1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end
  end

  ps2_evt_t      mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next_c;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next_c;
  logic          pop_c;
  logic          full_c;
  logic          wr_en_c;
  logic          ovf_c;
  ps2_evt_t      head_c;

  // Next head bypasses the write when the pushed entry becomes the head
  always_comb begin
    pop_c        = oEVT_VALID & iEVT_READY;
    full_c       = (count == CW'(FIFO_DEPTH));
    wr_en_c      = push_c & (~full_c | pop_c);
    ovf_c        = push_c & full_c & ~pop_c;
    rd_next_c    = rd_ptr + AW'(pop_c);
    count_next_c = count + CW'(wr_en_c) - CW'(pop_c);
    head_c       = (wr_en_c && wr_ptr == rd_next_c) ? evt_c : mem[rd_next_c];
  end

  always_ff @(posedge CLK50M) begin
    if (wr_en_c) mem[wr_ptr] <= evt_c;
  end

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      oEVT_VALID <= 1'b0;
      oEVT_CODE  <= '0;
      oEVT_BREAK <= 1'b0;
      oEVT_EXT   <= 1'b0;
      oOVF       <= 1'b0;
    end else begin
      rd_ptr     <= rd_next_c;
      wr_ptr     <= wr_ptr + AW'(wr_en_c);
      count      <= count_next_c;
      oOVF       <= ovf_c;
      oEVT_VALID <= (count_next_c != '0);
      if (count_next_c != '0) {oEVT_CODE, oEVT_BREAK, oEVT_EXT} <= head_c;
      else                    {oEVT_CODE, oEVT_BREAK, oEVT_EXT} <= '0;
    end
  end
endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Self-checking bench: frame-level model of the PS/2 decoder with a
// per-cycle compare process and directed plus randomized keyboard traffic.
module tb_ps2_rx_decoder;
  localparam int unsigned FILT  = 8;
  localparam int unsigned TO    = 1000;
  localparam int unsigned DEPTH = 4;
  localparam int          HALF  = 16;
  localparam int          LAT   = FILT + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ready = 1'b0;
  logic       valid;
  logic [7:0] code;
  logic       brk;
  logic       ext;
  logic       err;
  logic       ovf;

  ps2_rx_decoder #(.FILT_LEN(FILT), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
    .CLK50M(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .iEVT_READY(ready), .oEVT_VALID(valid), .oEVT_CODE(code),
    .oEVT_BREAK(brk), .oEVT_EXT(ext), .oERR(err), .oOVF(ovf)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ready_mode = 1;
  int          stop_fall_cyc = -100;
  int          rise_cyc = -1;
  logic [9:0]  rise_evt = '1;
  logic [9:0]  exp_q[$];
  bit          m_ext = 0;
  bit          m_brk = 0;
  int          exp_err = 0;
  int          act_err = 0;
  int          exp_ovf = 0;
  int          act_ovf = 0;
  logic        prev_valid = 0;
  logic        prev_ready = 0;
  logic [9:0]  prev_evt = '0;
  logic [7:0]  disc_tab [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Mode 3 raises ready for exactly the cycle whose edge writes the last frame's event
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      3:       ready = (cyc == stop_fall_cyc + 3 + int'(FILT));
      default: ready = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", 32'({valid, code, brk, ext, err, ovf}), 32'd0);
      prev_valid = 1'b0;
    end else begin
      if (err) act_err++;
      if (ovf) act_ovf++;
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_event", 32'({code, brk, ext}), 32'(prev_evt));
      end
      if (valid && !prev_valid) begin
        rise_cyc = cyc;
        rise_evt = {code, brk, ext};
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_event actual=%0h required=no_event", {code, brk, ext});
        end else begin
          check("event", 32'({code, brk, ext}), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = valid;
      prev_ready = ready;
      prev_evt   = {code, brk, ext};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Decode rules applied per received byte
  task automatic model_byte(input logic [7:0] b);
    bit disc;
    disc = 0;
    for (int i = 0; i < 6; i++) if (disc_tab[i] == b) disc = 1;
    if (b == 8'hE0 || b == 8'hE1) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (disc && !m_ext && !m_brk) ;
    else begin
      if (exp_q.size() >= int'(DEPTH) && ready_mode != 3) exp_ovf++;
      else exp_q.push_back({b, m_brk, m_ext});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    if (bad_par) exp_err++;
    else model_byte(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_par ? ^b : ~^b);
    ps2_dat = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    stop_fall_cyc = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    tick(4);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_err"}, 32'(act_err), 32'(exp_err));
    check({name, "_ovf"}, 32'(act_ovf), 32'(exp_ovf));
  endtask

  initial begin
    logic [7:0] b;
    int r;
    tick(5);
    check("reset_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    tick(5);

    // Plain make code with latency measurement
    rise_cyc = -1;
    send_frame(8'h1C, 0);
    drain("make_1c");
    check("lat_1c", 32'(rise_cyc - stop_fall_cyc), 32'(LAT));
    check("lit_1c", 32'(rise_evt), 32'({8'h1C, 1'b0, 1'b0}));

    // Extended break sequence
    rise_evt = '1;
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    drain("ext_break");
    check("lit_e0f075", 32'(rise_evt), 32'({8'h75, 1'b1, 1'b1}));

    // Parity error
    send_frame(8'h1C, 1);
    drain("parity");

    // Timeout mid-frame clears a pending break prefix
    send_frame(8'hF0, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_dat = 1'b1;
    tick(int'(TO) + 50);
    exp_err++;
    m_ext = 0;
    m_brk = 0;
    check("timeout_err", 32'(act_err), 32'(exp_err));
    rise_evt = '1;
    send_frame(8'h1C, 0);
    drain("after_timeout");
    check("lit_after_to", 32'(rise_evt), 32'({8'h1C, 1'b0, 1'b0}));

    // FIFO fill with consumer stalled, then push coinciding with pop
    ready_mode = 0;
    tick(3);
    send_frame(8'h16, 0);
    send_frame(8'h1E, 0);
    send_frame(8'h26, 0);
    send_frame(8'h25, 0);
    send_frame(8'h2E, 0);
    tick(20);
    check("ovf_count", 32'(act_ovf), 32'(exp_ovf));
    check("ovf_head", 32'({valid, code}), 32'({1'b1, 8'h16}));
    ready_mode = 3;
    send_frame(8'h36, 0);
    tick(20);
    check("full_pushpop_ovf", 32'(act_ovf), 32'd1);
    ready_mode = 1;
    drain("fifo_full");

    // Short glitch on the clock line with data low
    ps2_dat = 1'b0;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(HALF);
    ps2_dat = 1'b1;
    tick(int'(TO) + 50);
    drain("glitch");

    // Reset in the middle of a frame
    send_frame(8'hF0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_clk = 1'b0;
    tick(4);
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    m_ext = 0;
    m_brk = 0;
    tick(5);
    rst = 1'b0;
    tick(int'(TO) + 50);
    check("rst_no_err", 32'(act_err), 32'(exp_err));
    rise_evt = '1;
    send_frame(8'h1C, 0);
    drain("after_reset");
    check("lit_after_rst", 32'(rise_evt), 32'({8'h1C, 1'b0, 1'b0}));

    // Randomized traffic with random consumer stalls
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(99));
      if (r < 10)      b = 8'hE0;
      else if (r < 15) b = 8'hE1;
      else if (r < 25) b = 8'hF0;
      else if (r < 35) b = disc_tab[$urandom_range(5)];
      else             b = 8'($urandom_range(255));
      send_frame(b, $urandom_range(9) == 0);
      tick(int'($urandom_range(30)) + 1);
    end
    ready_mode = 1;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
